// File: rtl/bfp_pkg.sv
// bfp_pkg: shared types and parameter helpers for the block-floating-point exponent scheduler.
package bfp_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FINISH, WAIT, OUT} bfp_sched_state_t;
  typedef enum logic {SRC_A, SRC_B} bfp_src_t;
  function automatic int exp_w(input int bit_w, input int fpm);
    return bit_w - fpm - 1;
  endfunction
  function automatic int beats(input int v, input int p);
    return v / p;
  endfunction
endpackage

// File: rtl/bfp_exp_sched_if.sv
// bfp_exp_sched_if: source beats, exponent-unit side and result channel of the scheduler.
interface bfp_exp_sched_if import bfp_pkg::*; #(parameter int P = 4, parameter int BIT = 32, parameter int FPM = 23);
  localparam int EW = exp_w(BIT, FPM);
  logic [1:0] src_valid;
  logic [1:0] src_ready;
  logic [1:0][P*BIT-1:0] src_data;
  logic unit_clr;
  logic [P*BIT-1:0] unit_invals;
  logic unit_invals_rdy;
  logic unit_done;
  logic unit_valid_out;
  logic [EW-1:0] unit_exp;
  logic res_valid;
  logic res_ready;
  logic [EW-1:0] res_exp;
  logic res_owner;
  modport master (
    input src_valid, src_data, unit_valid_out, unit_exp, res_ready,
    output src_ready, unit_clr, unit_invals, unit_invals_rdy, unit_done, res_valid, res_exp, res_owner
  );
  modport slave (
    output src_valid, src_data, unit_valid_out, unit_exp, res_ready,
    input src_ready, unit_clr, unit_invals, unit_invals_rdy, unit_done, res_valid, res_exp, res_owner
  );
endinterface

// File: rtl/bfp_rr_arb2.sv
// bfp_rr_arb2: two-request round-robin arbiter; advance makes the loser of the current grant preferred.
module bfp_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       idx
);
  logic ptr;
  assign idx = req == 2'b11 ? ptr : req[1];
  assign gnt = req == 2'b00 ? 2'b00 : (idx ? 2'b10 : 2'b01);
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= 1'b0;
    else if (adv) ptr <= ~idx;
endmodule

// File: rtl/bfp_exp_sched.sv
// bfp_exp_sched: grants the shared largest-exponent unit to source A or B per block and returns the tagged exponent.
// Optional watchdog on the unit's valid flag: define BFP_SCHED_WDOG_EN.
module bfp_exp_sched import bfp_pkg::*; #(
  parameter int V = 8,
  parameter int P = 4,
  parameter int BIT = 32,
  parameter int FPM = 23
) (
  input logic clk,
  input logic reset,
  bfp_exp_sched_if.master bus
`ifdef BFP_SCHED_WDOG_EN
  , output logic sched_err
`endif
);
  localparam int EW = exp_w(BIT, FPM);
  localparam int BPB = beats(V, P);
  localparam int CW = $clog2(BPB) + 1;
  bfp_sched_state_t state;
  bfp_src_t owner;
  logic [CW-1:0] cnt;
  logic [1:0] gnt, own_oh;
  logic gidx, adv, acc, last, hs, tmo;
  logic clr_q, done_q, vld_q, rown;
  logic [EW-1:0] exp_q;
  assign own_oh = owner == SRC_B ? 2'b10 : 2'b01;
  assign acc = state == STREAM && bus.src_valid[owner];
  assign last = cnt == CW'(BPB - 1);
  assign hs = vld_q && bus.res_ready;
  assign adv = hs || tmo;
  // Outside IDLE the arbiter only sees the owner, so advance flips the pointer away from it.
  bfp_rr_arb2 u_arb (
    .clk(clk), .reset(reset),
    .req(state == IDLE ? bus.src_valid : own_oh),
    .adv(adv), .gnt(gnt), .idx(gidx)
  );
  assign bus.src_ready = state == STREAM ? own_oh : 2'b00;
  assign bus.unit_invals = bus.src_data[owner];
  assign bus.unit_invals_rdy = acc;
  assign bus.unit_clr = clr_q;
  assign bus.unit_done = done_q;
  assign bus.res_valid = vld_q;
  assign bus.res_exp = exp_q;
  assign bus.res_owner = rown;
`ifdef BFP_SCHED_WDOG_EN
  logic [3:0] wd;
  assign tmo = state == WAIT && !bus.unit_valid_out && wd == 4'd14;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wd <= '0;
      sched_err <= 1'b0;
    end else begin
      wd <= state == WAIT ? wd + 4'd1 : 4'd0;
      sched_err <= tmo;
    end
`else
  assign tmo = 1'b0;
`endif
  // clr_q resets high so the unit is cleared whenever the scheduler is.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= SRC_A;
      cnt <= '0;
      clr_q <= 1'b1;
      done_q <= 1'b0;
      vld_q <= 1'b0;
      exp_q <= '0;
      rown <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: if (|gnt) begin
          owner <= bfp_src_t'(gidx);
          clr_q <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: state <= STREAM;
        STREAM: if (acc) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            done_q <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: state <= WAIT;
        WAIT: if (bus.unit_valid_out) begin
          exp_q <= bus.unit_exp;
          rown <= owner;
          vld_q <= 1'b1;
          state <= OUT;
        end else if (tmo) state <= IDLE;
        OUT: if (hs) begin
          vld_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
